// File: rtl/counter_modn_flag_if.sv
// rtl/counter_modn_flag_if.sv - control and status bundle for the modulo-N flag counter
interface counter_modn_flag_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             en;
  logic             up_dn;
  logic             mode_wrap;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             flag;
  logic             tc;
  logic             running;

  modport master (
    output start, en, up_dn, mode_wrap, load, load_value,
    input  count, flag, tc, running
  );

  modport slave (
    input  start, en, up_dn, mode_wrap, load, load_value,
    output count, flag, tc, running
  );
endinterface

// File: rtl/counter_modn_flag.sv
// rtl/counter_modn_flag.sv - modulo-N up/down counter with sticky threshold flag and tc pulse
module counter_modn_flag #(
  parameter int MODULUS   = 8,
  parameter int WIDTH     = 3,
  parameter int THRESHOLD = 4
) (
  input logic                clock,
  input logic                clearn,
  counter_modn_flag_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] THR  = WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic             flag_q;
  logic             tc_q;
  logic             running_q;
  logic             at_term;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_sat;

  // step_val is the next count in the current direction, already wrapped at the terminal value
  always_comb begin
    load_sat = (bus.load_value > TOP) ? TOP : bus.load_value;
    at_term  = bus.up_dn ? (count_q == TOP) : (count_q == ZERO);
    if (at_term) step_val = bus.up_dn ? ZERO : TOP;
    else         step_val = bus.up_dn ? (count_q + ONE) : (count_q - ONE);
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state     <= IDLE;
      count_q   <= ZERO;
      flag_q    <= 1'b0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.load) begin
        count_q   <= load_sat;
        flag_q    <= 1'b0;
        state     <= IDLE;
        running_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state     <= RUN;
              running_q <= 1'b1;
              flag_q    <= 1'b0;
            end
          end
          RUN: begin
            if (bus.en) begin
              if (at_term) tc_q <= 1'b1;
              // one-shot parks on the terminal value; flag only reacts to an actual move
              if (at_term && !bus.mode_wrap) begin
                state     <= DONE;
                running_q <= 1'b0;
              end else begin
                count_q <= step_val;
                if (step_val == THR) flag_q <= 1'b1;
              end
            end
          end
          DONE: begin
            if (bus.start) begin
              state     <= RUN;
              running_q <= 1'b1;
              flag_q    <= 1'b0;
              count_q   <= bus.up_dn ? ZERO : TOP;
            end
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.flag    = flag_q;
  assign bus.tc      = tc_q;
  assign bus.running = running_q;
endmodule

// File: tb/tb_counter_modn_flag.sv
// tb/tb_counter_modn_flag.sv - scoreboard bench for counter_modn_flag (mod-8 default and mod-10)
module tb_counter_modn_flag;
  localparam int IDLE_S = 0;
  localparam int RUN_S  = 1;
  localparam int DONE_S = 2;

  logic clock = 1'b0;
  logic clearn;
  always #5 clock = ~clock;

  counter_modn_flag_if #(.WIDTH(3)) if8 ();
  counter_modn_flag_if #(.WIDTH(4)) if10 ();

  counter_modn_flag dut8 (.clock(clock), .clearn(clearn), .bus(if8.slave));
  counter_modn_flag #(.MODULUS(10), .WIDTH(4), .THRESHOLD(9)) dut10 (
    .clock(clock), .clearn(clearn), .bus(if10.slave));

  logic       s_ld[2], s_st[2], s_en[2], s_up[2], s_wr[2];
  logic [3:0] s_lv[2];

  assign if8.load        = s_ld[0];
  assign if8.start       = s_st[0];
  assign if8.en          = s_en[0];
  assign if8.up_dn       = s_up[0];
  assign if8.mode_wrap   = s_wr[0];
  assign if8.load_value  = s_lv[0][2:0];
  assign if10.load       = s_ld[1];
  assign if10.start      = s_st[1];
  assign if10.en         = s_en[1];
  assign if10.up_dn      = s_up[1];
  assign if10.mode_wrap  = s_wr[1];
  assign if10.load_value = s_lv[1];

  int m_cnt[2];
  int m_st[2];
  bit m_fl[2];
  bit m_tc[2];
  int mm[2] = '{8, 10};
  int th[2] = '{4, 9};
  int wd[2] = '{3, 4};

  logic [6:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [8:0] stim(logic ld, logic st, logic en, logic up, logic wr, logic [3:0] lv);
    return {ld, st, en, up, wr, lv};
  endfunction

  function automatic logic [6:0] pack(int id);
    return {4'(m_cnt[id]), m_fl[id], m_tc[id], (m_st[id] == RUN_S)};
  endfunction

  function automatic logic [6:0] obs(int id);
    if (id == 0) return {1'b0, if8.count, if8.flag, if8.tc, if8.running};
    return {if10.count, if10.flag, if10.tc, if10.running};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_st[k] = IDLE_S; m_fl[k] = 1'b0; m_tc[k] = 1'b0;
    end
  endtask

  task automatic model_step(int id);
    int lv;
    lv = int'(s_lv[id]) % (1 << wd[id]);
    m_tc[id] = 1'b0;
    if (s_ld[id]) begin
      m_cnt[id] = (lv >= mm[id]) ? mm[id] - 1 : lv;
      m_fl[id]  = 1'b0;
      m_st[id]  = IDLE_S;
    end else if (m_st[id] == IDLE_S) begin
      if (s_st[id]) begin m_st[id] = RUN_S; m_fl[id] = 1'b0; end
    end else if (m_st[id] == DONE_S) begin
      if (s_st[id]) begin
        m_st[id]  = RUN_S;
        m_fl[id]  = 1'b0;
        m_cnt[id] = s_up[id] ? 0 : mm[id] - 1;
      end
    end else if (s_en[id]) begin
      if ((s_up[id] && m_cnt[id] == mm[id] - 1) || (!s_up[id] && m_cnt[id] == 0)) begin
        m_tc[id] = 1'b1;
        if (s_wr[id]) begin
          m_cnt[id] = s_up[id] ? 0 : mm[id] - 1;
          if (m_cnt[id] == th[id]) m_fl[id] = 1'b1;
        end else begin
          m_st[id] = DONE_S;
        end
      end else begin
        m_cnt[id] = s_up[id] ? m_cnt[id] + 1 : m_cnt[id] - 1;
        if (m_cnt[id] == th[id]) m_fl[id] = 1'b1;
      end
    end
  endtask

  task automatic cyc(int id, logic [8:0] s);
    {s_ld[id], s_st[id], s_en[id], s_up[id], s_wr[id], s_lv[id]} = s;
    model_step(0);
    model_step(1);
    exp_q.push_back(pack(id));
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got, want;
    clearn = 1'b0;
    #12;
    model_reset();
    for (int id = 0; id < 2; id++) begin
      got = obs(id); want = pack(id); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset dut%0d got %b want %b (count,flag,tc,running)", id, got, want);
      end
    end
    clearn = 1'b1;
  endtask

  task automatic test_oneshot_up();
    logic [6:0] got, want;
    for (int i = 0; i < 11; i++) begin
      cyc(0, stim(0, i == 0, 1, 1, 0, 0));
      got = obs(0); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL oneshot_up step %0d got %b want %b (count,flag,tc,running)", i, got, want);
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [6:0] got, want;
    for (int i = 0; i < 12; i++) begin
      cyc(0, stim(0, i == 0, 1, 1, 1, 0));
      got = obs(0); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap_up step %0d got %b want %b (count,flag,tc,running)", i, got, want);
      end
    end
  endtask

  task automatic test_down_oneshot();
    logic [8:0] seq[9];
    logic [6:0] got, want;
    seq = '{stim(1, 0, 0, 0, 0, 2), stim(0, 1, 1, 0, 0, 0), stim(0, 0, 1, 0, 0, 0),
            stim(0, 0, 1, 0, 0, 0), stim(0, 0, 1, 0, 0, 0), stim(0, 0, 1, 0, 0, 0),
            stim(0, 1, 0, 0, 0, 0), stim(0, 0, 1, 0, 0, 0), stim(0, 0, 0, 1, 0, 0)};
    for (int i = 0; i < 9; i++) begin
      cyc(0, seq[i]);
      got = obs(0); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL down_oneshot step %0d got %b want %b (count,flag,tc,running)", i, got, want);
      end
    end
  endtask

  task automatic test_load_priority();
    int         ids[9];
    logic [8:0] seq[9];
    logic [6:0] got, want;
    ids = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    seq = '{stim(1, 1, 1, 1, 0, 7), stim(0, 1, 0, 1, 1, 0), stim(0, 0, 1, 1, 1, 0),
            stim(0, 0, 1, 1, 1, 0), stim(0, 0, 1, 1, 1, 0), stim(1, 1, 1, 1, 1, 12),
            stim(0, 1, 0, 1, 1, 0), stim(0, 0, 1, 1, 1, 0), stim(0, 0, 1, 1, 1, 0)};
    for (int i = 0; i < 9; i++) begin
      cyc(ids[i], seq[i]);
      got = obs(ids[i]); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL load_priority step %0d dut%0d got %b want %b (count,flag,tc,running)",
                 i, ids[i], got, want);
      end
    end
  endtask

  task automatic test_dir_change();
    logic [6:0] got, want;
    for (int i = 0; i < 34; i++) begin
      if (i == 0)      cyc(0, stim(1, 0, 0, 1, 1, 3));
      else if (i == 1) cyc(0, stim(0, 1, 0, 1, 1, 0));
      else cyc(0, stim(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1, 0));
      got = obs(0); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL dir_change step %0d got %b want %b (count,flag,tc,running)", i, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] got, want;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      cyc(0, stim(1, 0, 0, 1, 0, 5));
      else if (i == 1) cyc(0, stim(0, 1, 1, 1, 0, 0));
      else             cyc(0, stim(0, 0, 1, 1, 0, 0));
      got = obs(0); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL async_reset pre step %0d got %b want %b (count,flag,tc,running)", i, got, want);
      end
    end
    #3 clearn = 1'b0;
    #1;
    model_reset();
    got = obs(0); want = pack(0); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL async_reset immediate got %b want %b (count,flag,tc,running)", got, want);
    end
    #2 clearn = 1'b1;
    cyc(0, stim(0, 0, 1, 1, 0, 0));
    got = obs(0); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL async_reset after got %b want %b (count,flag,tc,running)", got, want);
    end
  endtask

  task automatic test_mod10();
    logic [6:0] got, want;
    for (int i = 0; i < 32; i++) begin
      cyc(1, stim(0, i == 0, (i % 3) != 2, 1, 1, 0));
      got = obs(1); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mod10 step %0d got %b want %b (count,flag,tc,running)", i, got, want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      s_ld[k] = 1'b0; s_st[k] = 1'b0; s_en[k] = 1'b0;
      s_up[k] = 1'b0; s_wr[k] = 1'b0; s_lv[k] = 4'd0;
    end
    test_reset();
    test_oneshot_up();
    test_wrap_up();
    test_down_oneshot();
    test_load_priority();
    test_dir_change();
    test_async_reset();
    test_mod10();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
